// File: rtl/seq_detect_if.sv
// Serial pattern detector port bundle.
// Sampling inputs plus registered detector outputs.
interface seq_detect_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             EN;
  logic             DIN;
  logic             HIT;
  logic [CNT_W-1:0] HIT_CNT;
  logic [PAT_W-1:0] WINDOW;

  modport master (
    output EN,
    output DIN,
    input  HIT,
    input  HIT_CNT,
    input  WINDOW
  );

  modport slave (
    input  EN,
    input  DIN,
    output HIT,
    output HIT_CNT,
    output WINDOW
  );
endinterface

// File: rtl/seq_detect.sv
// Sliding-window serial pattern detector with a
// one-cycle hit pulse and a saturating match counter.
module seq_detect #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic        CP,
  input  logic        RST,
  seq_detect_if.slave bus
);
  localparam int FW = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] nxt;
  logic [FW-1:0]    fill;
  logic [CNT_W-1:0] cnt;
  logic             hit;
  logic             match;

  assign nxt = {window[PAT_W-2:0], bus.DIN};

  // fill gate keeps reset zeros out of a match
  assign match = (nxt == PATTERN) &&
                 (fill >= FW'(PAT_W - 1));

  always_ff @(posedge CP) begin
    if (RST) begin
      window <= '0;
      fill   <= '0;
      hit    <= 1'b0;
      cnt    <= '0;
    end else if (bus.EN) begin
      window <= nxt;
      hit    <= match;
      if (match && (cnt != '1))
        cnt <= cnt + CNT_W'(1);
      if (match && !OVERLAP)
        fill <= '0;
      else if (fill != FW'(PAT_W))
        fill <= fill + FW'(1);
    end else begin
      hit <= 1'b0;
    end
  end

  assign bus.HIT     = hit;
  assign bus.HIT_CNT = cnt;
  assign bus.WINDOW  = window;
endmodule
